// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential multiply/divide unit: func codes
// decoded from the EX/ID stages, FSM state encodings and the default
// iteration count.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  // HI/LO access func codes (op == 0)
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  // Start func codes (op == 0)
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Operation kind; the encoding equals func[1:0] of the start ops.
  typedef enum logic [1:0] {
    K_MULT  = 2'd0,
    K_MULTU = 2'd1,
    K_DIV   = 2'd2,
    K_DIVU  = 2'd3
  } op_kind_t;

  // Magnitude of a 32-bit value when it is treated as signed, else raw.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: shift-add, {hi,lo} holds {partial product, remaining multiplier}.
// Divide: restoring, {hi,lo} holds {partial remainder, dividend/quotient}.
module muldiv_step (
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_opnd,   // multiplicand or divisor
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [32:0] w_sum;
  logic [32:0] w_acc;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;

  // Add the multiplicand when the current multiplier bit is set; the
  // 33rd bit carries into the right shift so no product bit is lost.
  assign w_sum   = {1'b0, i_hi} + {1'b0, i_opnd};
  assign w_acc   = i_lo[0] ? w_sum : {1'b0, i_hi};

  // Shift the next dividend bit into the remainder and trial-subtract.
  // The shifted remainder can exceed 32 bits, so compare at 33 bits.
  assign w_shift = {i_hi, i_lo[31]};
  assign w_ge    = (w_shift >= {1'b0, i_opnd});
  assign w_diff  = w_shift - {1'b0, i_opnd};

  // Select the multiply or divide result for this iteration
  always_comb begin
    if (i_is_div) begin
      o_hi = w_ge ? w_diff[31:0] : w_shift[31:0];
      o_lo = {i_lo[30:0], w_ge};
    end else begin
      o_hi = w_acc[32:1];
      o_lo = {w_acc[0], i_lo[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit for the EX stage. Takes ITER+2
// cycles from the start cycle to the one-cycle done pulse, and stalls the
// front of the pipeline while ID wants HI/LO or another multiply/divide.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int ITER   = ITER_DEFAULT,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FUNC_W-1:0] EX_op,
  input  logic [FUNC_W-1:0] EX_func,
  input  logic [31:0]       EX_busA,
  input  logic [31:0]       EX_busB,
  input  logic [FUNC_W-1:0] ID_op,
  input  logic [FUNC_W-1:0] ID_func,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [63:0]       MULT_result
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_opnd;
  op_kind_t         r_kind;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_is_div;
  logic             r_div0;
  logic [63:0]      r_result;

  logic             w_ex_start;
  logic             w_id_hazard;
  logic             w_start;
  logic             w_ex_signed;
  logic             w_ex_div;
  op_kind_t         w_ex_kind;
  logic [31:0]      w_mag_a;
  logic [31:0]      w_mag_b;
  logic [31:0]      w_init_lo;
  logic [31:0]      w_init_opnd;
  logic             w_idle;
  logic             w_step_div;
  logic [31:0]      w_step_hi;
  logic [31:0]      w_step_lo;
  logic [31:0]      w_step_opnd;
  logic [31:0]      w_nxt_hi;
  logic [31:0]      w_nxt_lo;
  logic [63:0]      w_fix;

  function automatic logic f_is_start(input logic [FUNC_W-1:0] f);
    return (f == FUNC_W'(FN_MULT)) || (f == FUNC_W'(FN_MULTU)) ||
           (f == FUNC_W'(FN_DIV))  || (f == FUNC_W'(FN_DIVU));
  endfunction

  function automatic logic f_is_hilo(input logic [FUNC_W-1:0] f);
    return (f == FUNC_W'(FN_MFHI)) || (f == FUNC_W'(FN_MTHI)) ||
           (f == FUNC_W'(FN_MFLO)) || (f == FUNC_W'(FN_MTLO));
  endfunction

  // Decode of the EX and ID instructions
  assign w_ex_start  = (EX_op == '0) && f_is_start(EX_func);
  assign w_id_hazard = (ID_op == '0) && (f_is_start(ID_func) || f_is_hilo(ID_func));
  assign w_ex_div    = EX_func[1];
  assign w_ex_signed = ~EX_func[0];
  assign w_ex_kind   = op_kind_t'(EX_func[1:0]);

  assign w_idle  = (r_state == ST_IDLE);
  // Acceptance only happens in IDLE, where busy (and so a busy-driven
  // stall) is low; stall raised in the start cycle only holds back ID.
  assign w_start = w_idle && w_ex_start;

  assign busy  = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign stall = (busy || w_start) && w_id_hazard;
  assign done  = (r_state == ST_DONE);
  assign MULT_result = r_result;

  // Initial datapath pair: multiply iterates over the multiplier in lo,
  // divide shifts the dividend out of lo; both start from magnitudes.
  assign w_mag_a     = abs32(EX_busA, w_ex_signed);
  assign w_mag_b     = abs32(EX_busB, w_ex_signed);
  assign w_init_lo   = w_ex_div ? w_mag_a : w_mag_b;
  assign w_init_opnd = w_ex_div ? w_mag_b : w_mag_a;

  // The first iteration runs in the start cycle itself, straight from EX,
  // which is what makes the whole operation fit in ITER+2 cycles.
  assign w_step_div  = w_idle ? w_ex_div    : r_is_div;
  assign w_step_hi   = w_idle ? 32'd0       : r_hi;
  assign w_step_lo   = w_idle ? w_init_lo   : r_lo;
  assign w_step_opnd = w_idle ? w_init_opnd : r_opnd;

  muldiv_step u_step (
    .i_is_div (w_step_div),
    .i_hi     (w_step_hi),
    .i_lo     (w_step_lo),
    .i_opnd   (w_step_opnd),
    .o_hi     (w_nxt_hi),
    .o_lo     (w_nxt_lo)
  );

  // Sign fix-up of the unsigned magnitude result for MULT and DIV
  always_comb begin
    // NOTE: default first so every path assigns w_fix and no latch is inferred.
    w_fix = {r_hi, r_lo};
    case (r_kind)
      K_MULT: begin
        if (r_sign_a ^ r_sign_b) w_fix = -{r_hi, r_lo};
      end
      K_DIV: begin
        // A zero divisor keeps the all-ones quotient; the remainder still
        // takes the dividend's sign, which restores the original dividend.
        if ((r_sign_a ^ r_sign_b) && !r_div0) w_fix[31:0] = -r_lo;
        if (r_sign_a) w_fix[63:32] = -r_hi;
      end
      default: ;
    endcase
  end

  // FSM, iteration counter and datapath registers
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: operand and sign registers are reset too, so an abandoned
      // operation leaves nothing behind for the next one to see.
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_kind   <= K_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_hi     <= w_nxt_hi;
            r_lo     <= w_nxt_lo;
            r_opnd   <= w_init_opnd;
            r_kind   <= w_ex_kind;
            r_sign_a <= w_ex_signed & EX_busA[31];
            r_sign_b <= w_ex_signed & EX_busB[31];
            r_is_div <= w_ex_div;
            r_div0   <= w_ex_div && (EX_busB == 32'd0);
            r_cnt    <= CNT_W'(ITER - 1);
            r_state  <= (ITER > 1) ? ST_CALC : ST_FIX;
          end
        end
        ST_CALC: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_cnt <= r_cnt - 1'b1;
          // Leave CALC as the counter reaches zero.
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_state  <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a small pipeline model feeds ID/EX and
// honours stall; every start op reaching EX pushes its expected result and
// done cycle, and a monitor checks done/busy/result every cycle.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int ITER = 32;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } instr_t;

  typedef struct {
    logic [63:0] res;
    int          start_cyc;
    int          done_cyc;
  } exp_t;

  localparam instr_t NOP = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, stall, done;
  logic [63:0] MULT_result;
  instr_t      ex, id;

  instr_t      prog[$];
  exp_t        sb[$];
  int          starts[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] last_res = '0;
  logic [63:0] dut_last = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.ITER(ITER), .FUNC_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .EX_op       (ex.op),
    .EX_func     (ex.func),
    .EX_busA     (ex.a),
    .EX_busB     (ex.b),
    .ID_op       (id.op),
    .ID_func     (id.func),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .MULT_result (MULT_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i.op = 6'd0; i.func = func; i.a = a; i.b = b;
    return i;
  endfunction

  function automatic logic tb_is_start(input instr_t i);
    return (i.op == 6'd0) && (i.func >= 6'h18) && (i.func <= 6'h1B);
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [63:0] ref_result(input instr_t i);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa  = longint'($signed(i.a));
    sb_ = longint'($signed(i.b));
    ua  = {32'd0, i.a};
    ub  = {32'd0, i.b};
    case (i.func)
      FN_MULT:  return sa * sb_;
      FN_MULTU: return ua * ub;
      FN_DIV: begin
        if (i.b == 32'd0) return {i.a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (i.b == 32'd0) return {i.a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 9);
    i = mk(6'd0, rand_val(), rand_val());
    case (k)
      0, 1, 2, 3: i.func = 6'h18 + 6'(k);
      4: i.func = FN_MFHI;
      5: i.func = FN_MFLO;
      6: i.func = FN_MTHI;
      7: i.func = FN_MTLO;
      8: begin i.op = 6'h23; i.func = FN_MULT; end
      default: i.func = 6'h20;
    endcase
    return i;
  endfunction

  // Pipeline model: ID/EX advance unless stall was high, in which case ID
  // holds and EX takes a bubble. Start ops reaching EX are scoreboarded.
  initial begin
    logic s;
    ex = NOP;
    id = NOP;
    forever begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      cyc++;
      #1;
      if (s === 1'b1) begin
        ex = NOP;
      end else begin
        ex = id;
        id = (prog.size() > 0) ? prog.pop_front() : NOP;
      end
      if (tb_is_start(ex)) begin
        sb.push_back('{res: ref_result(ex), start_cyc: cyc, done_cyc: cyc + ITER + 1});
        starts.push_back(cyc);
      end
    end
  end

  // Monitor: done timing, busy window and result hold, every cycle.
  initial begin
    logic exp_done, exp_busy;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
        exp_busy = (sb.size() > 0) && (cyc > sb[0].start_cyc) && (cyc <= sb[0].start_cyc + ITER);
        check("done", 64'(done), 64'(exp_done));
        check("busy", 64'(busy), 64'(exp_busy));
        if (exp_done) begin
          check("result", MULT_result, sb[0].res);
          last_res = sb[0].res;
          dut_last = MULT_result;
          void'(sb.pop_front());
        end else begin
          check("result_hold", MULT_result, last_res);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((prog.size() > 0 || sb.size() > 0 || tb_is_start(id) || tb_is_start(ex)) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout @cyc %0d: pending=%0d expected 0", cyc, sb.size());
      sb.delete();
      prog.delete();
    end
  endtask

  task automatic wait_start(output int s0);
    int n;
    n = 0;
    while (starts.size() == 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (starts.size() == 0) begin
      bad++;
      $display("FAIL start_timeout @cyc %0d: got no start expected one", cyc);
      s0 = cyc;
    end else begin
      s0 = starts[0];
    end
  endtask

  initial begin
    int s0, rel;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", MULT_result, 64'd0);

    // Directed values
    prog.push_back(mk(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    wait_idle(200);
    check("multu_max", dut_last, 64'hFFFF_FFFE_0000_0001);

    prog.push_back(mk(FN_MULT, -32'sd3, 32'd7));
    wait_idle(200);
    check("mult_neg", dut_last, 64'hFFFF_FFFF_FFFF_FFEB);

    prog.push_back(mk(FN_DIV, -32'sd7, 32'd2));
    wait_idle(200);
    check("div_neg", dut_last, 64'hFFFF_FFFF_FFFF_FFFD);

    prog.push_back(mk(FN_DIVU, 32'd7, 32'd0));
    wait_idle(200);
    check("divu_zero", dut_last, 64'h0000_0007_FFFF_FFFF);

    prog.push_back(mk(FN_DIV, -32'sd9, 32'd0));
    wait_idle(200);
    check("div_zero_signed", dut_last, 64'hFFFF_FFF7_FFFF_FFFF);

    // MFLO in ID from the cycle after start: stall window and release
    starts.delete();
    prog.push_back(mk(FN_MULT, 32'd5, 32'd6));
    prog.push_back(NOP);
    prog.push_back(mk(FN_MFLO, 32'd0, 32'd0));
    wait_start(s0);
    for (int n = 0; n < ITER + 2; n++) begin
      @(negedge clk);
      rel = cyc - s0 + 1;
      check($sformatf("mflo_stall_c%0d", rel), 64'(stall), 64'((rel >= 2) && (rel <= ITER + 1)));
    end
    @(posedge clk);
    #2;
    check("mflo_proceeds", 64'(ex.func), 64'(FN_MFLO));
    wait_idle(200);

    // Back-to-back starts: the second waits for DONE, then starts
    starts.delete();
    prog.push_back(mk(FN_MULT, 32'h1234_5678, -32'sd77));
    prog.push_back(mk(FN_MULT, -32'sd1, 32'h8000_0000));
    wait_idle(400);
    check("b2b_count", 64'(starts.size()), 64'd2);
    if (starts.size() == 2)
      check("b2b_gap", 64'(starts[1] - starts[0]), 64'(ITER + 2));

    // MULT func with a non-zero opcode is not a start op
    prog.push_back('{op: 6'h23, func: FN_MULT, a: 32'd3, b: 32'd3});
    repeat (4) @(negedge clk);
    check("nonrtype_idle", 64'(busy), 64'd0);
    wait_idle(50);

    // Reset in cycle 10 of a DIV abandons it
    starts.delete();
    prog.push_back(mk(FN_DIV, -32'sd100, 32'd7));
    wait_start(s0);
    while (cyc < s0 + 9) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    sb.delete();
    last_res = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", MULT_result, 64'd0);
    repeat (ITER) @(negedge clk);
    prog.push_back(mk(FN_MULTU, 32'd2, 32'd3));
    wait_idle(200);
    check("post_reset_multu", dut_last, 64'd6);

    // Randomized instruction stream, mixed with HI/LO accesses
    for (int n = 0; n < 40; n++) prog.push_back(rand_instr());
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog @cyc %0d: simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
